multi_sched_rr: RTL
===================

MULTI_SCHED_RR -- requirements
Module: multi_sched_rr

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing the multiplier.
REQ-002 The block SHALL have parameter W, default 16, operand width.
REQ-003 The block SHALL have parameter TIMEOUT, default 24, the maximum number of WAIT cycles before abort.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk_i  in  1  single clock, rising edge.
REQ-006 Port: rst_i  in  1  asynchronous active-low reset.
REQ-007 Port: req_valid_i  in  N_REQ  per-requester operation request.
REQ-008 Port: req_ready_o  out  N_REQ  per-requester grant; one-hot or zero.
REQ-009 Port: req_a_i, req_b_i  in  N_REQ x W  per-requester operands.
REQ-010 Port: mul_a_o, mul_b_o  out  W  operands driven to the shared sequential multiplier.
REQ-011 Port: mul_start_o  out  1  one-cycle start pulse to the multiplier.
REQ-012 Port: mul_done_i  in  1  multiplier completion flag.
REQ-013 Port: mul_p_i  in  2W  multiplier product.
REQ-014 Port: resp_valid_o / resp_ready_i  out / in  1 / 1  response handshake.
REQ-015 Port: resp_id_o  out  clog2(N_REQ)  index of the served requester.
REQ-016 Port: resp_p_o  out  2W  product returned.
REQ-017 Port: resp_err_o  out  1  timeout abort flag.
REQ-018 Port: busy_o  out  1  high when the state is not IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE with any req_valid_i set, the block SHALL assert req_ready_o[g] combinationally for the round-robin winner g. The search SHALL start at ptr and wrap modulo N_REQ.
REQ-021 On that IDLE accept cycle, the block SHALL latch the winner's a, b and g.
REQ-022 After the IDLE accept, the FSM SHALL move to RESP if either operand is 0. In that case resp_p_o = 0, resp_err_o = 0 and no start pulse is issued.
REQ-023 After the IDLE accept with both operands non-zero, the FSM SHALL move to ISSUE.
REQ-024 In ISSUE, mul_start_o SHALL be 1 for exactly one cycle. The latched operands SHALL be stable on mul_a_o/mul_b_o from ISSUE through the end of WAIT. The FSM SHALL move to WAIT and clear the wait counter.
REQ-025 In WAIT, when mul_done_i = 1, the block SHALL capture mul_p_i into resp_p_o and move to RESP.
REQ-026 In WAIT without mul_done_i, the wait counter SHALL increment. When the counter equals TIMEOUT-1, the block SHALL move to RESP with resp_err_o = 1 and resp_p_o = 0.
REQ-027 mul_done_i SHALL be ignored in every state other than WAIT.
REQ-028 In RESP, resp_valid_o SHALL be held with resp_id_o, resp_p_o and resp_err_o stable until resp_ready_i = 1.
REQ-029 On the RESP handshake cycle, the block SHALL set ptr = (g+1) mod N_REQ and return to IDLE.
REQ-030 No new grant SHALL occur in the RESP handshake cycle.
REQ-031 Latency for non-zero operands SHALL be as follows. Accept in cycle 0, start in cycle 1. If done arrives in cycle 1+L, resp_valid_o rises in cycle 2+L.
REQ-032 Latency for a zero operand SHALL be: resp_valid_o in cycle 1.
REQ-033 req_ready_o SHALL be all-zero outside IDLE. Requesters not granted keep their requests pending; no request is dropped.
REQ-034 resp_p_o SHALL be the full 2W-bit unsigned product, with no truncation.

Reset
REQ-035 rst_i = 0 SHALL asynchronously force the following: state IDLE, ptr = 0, counter = 0, and all outputs 0 (req_ready_o, mul_start_o, mul_a_o, mul_b_o, resp_valid_o, resp_id_o, resp_p_o, resp_err_o, busy_o).
REQ-036 A reset asserted mid-operation SHALL abandon the operation with no response. A mul_done_i arriving after the release of reset SHALL be ignored.

Structure
REQ-037 The shared package multi_pkg SHALL hold the state enum type, the default W, N_REQ and TIMEOUT values, and the ID width function.
REQ-038 The round-robin priority pick SHALL be a separate sub-module rr_arbiter_n (inputs: request vector and ptr; output: one-hot grant). It SHALL be purely combinational.

Verification
REQ-039 The bench SHALL cover single request: req 2, a=3, b=5, multiplier model L=17 -> start in cycle 1, resp_valid in cycle 19, id=2, p=15, err=0.
REQ-040 The bench SHALL cover the fairness case: all 4 requests held continuously, ptr=0 -> grants in order 0,1,2,3,0, one grant per completed response.
REQ-041 The bench SHALL cover the zero shortcut: req 1, a=0, b=0xFFFF -> no mul_start_o, resp_valid in cycle 1, p=0.
REQ-042 The bench SHALL cover maximum operands: a=b=0xFFFF -> p=0xFFFE0001, err=0.
REQ-043 The bench SHALL cover timeout and backpressure: model never asserts done -> resp_valid after TIMEOUT WAIT cycles with err=1, p=0. With resp_ready_i held low for 5 cycles, outputs stay stable and no grant occurs.
REQ-044 The bench SHALL cover reset in WAIT: rst_i low for 1 cycle -> all outputs 0 and ptr=0. A late mul_done_i pulse produces no response.

Source files
------------

// File: rtl/multi_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
package multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 24;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin pick: lowest-index request at or after ptr, wrapping, as a
// one-hot grant. Purely combinational.
module rr_arbiter_n
  import multi_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IW = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   pick;
  logic [2*N_REQ-1:0] dbl_g;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    pick  = rot & (~rot + N_REQ'(1));
    dbl_g = {{N_REQ{1'b0}}, pick} << ptr;
    grant = dbl_g[N_REQ-1:0] | dbl_g[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/multi_sched_rr.sv
// Shares one sequential multiplier among N_REQ requesters with round-robin
// arbitration, a zero-operand shortcut and a WAIT timeout.
//
//   state | meaning
//   IDLE  | offer grant to the round-robin winner, latch its operands
//   ISSUE | one-cycle start pulse to the multiplier
//   WAIT  | wait for mul_done_i, abort after TIMEOUT cycles
//   RESP  | hold the response until resp_ready_i
module multi_sched_rr
  import multi_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW = id_width(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ-1:0][W-1:0]   req_a_i,
  input  logic [N_REQ-1:0][W-1:0]   req_b_i,
  output logic [W-1:0]              mul_a_o,
  output logic [W-1:0]              mul_b_o,
  output logic                      mul_start_o,
  input  logic                      mul_done_i,
  input  logic [2*W-1:0]            mul_p_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [IW-1:0]             resp_id_o,
  output logic [2*W-1:0]            resp_p_o,
  output logic                      resp_err_o,
  output logic                      busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      id_q;
  logic [W-1:0]       a_q, b_q;
  logic [2*W-1:0]     p_q;
  logic               err_q;
  logic [CW-1:0]      cnt_q;

  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      win_id;
  logic [W-1:0]       win_a, win_b;
  logic               accept;
  logic               win_zero;
  logic               cnt_last;

  rr_arbiter_n #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant and mux the winner's operands.
  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_id = IW'(i);
        win_a  = win_a | req_a_i[i];
        win_b  = win_b | req_b_i[i];
      end
    end
  end

  assign accept   = (state_q == ST_IDLE) && (|grant);
  assign win_zero = (win_a == '0) || (win_b == '0);
  assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = win_zero ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mul_done_i || cnt_last) state_d = ST_RESP;
      ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand/response latches, wait counter and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q  <= win_id;
            a_q   <= win_a;
            b_q   <= win_b;
            p_q   <= '0;
            err_q <= 1'b0;
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (mul_done_i) begin
            p_q <= mul_p_i;
          end else if (cnt_last) begin
            p_q   <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready_i)
            ptr_q <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE) ? grant : '0;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign mul_start_o  = (state_q == ST_ISSUE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_id_o    = id_q;
  assign resp_p_o     = p_q;
  assign resp_err_o   = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
